// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and FSM state type.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration on the {acc, q} work pair: shift-add for multiply,
// restoring compare-subtract-shift for divide (m is multiplicand or divisor magnitude).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc_i} + {1'b0, m_i & {WIDTH{q_i[0]}}};
    rem  = {acc_i, q_i[WIDTH-1]};
    ge   = (rem >= {1'b0, m_i});
    // When the subtract is taken the result is below m, so the low bits are exact.
    diff = rem[WIDTH-1:0] - m_i;
    if (is_div) begin
      acc_o = ge ? diff : rem[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], ge};
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/pipe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; WIDTH+1 edges per op, start ignored while busy.
// Define MDU_EARLY_TERM_EN to let multiplies finish once the remaining multiplier bits are zero.
module pipe_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic             dz_op_q, dz_op_d, dz_q, dz_d;

  logic [WIDTH-1:0]   step_acc, step_q, a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic               op_div, op_signed, a_neg, b_neg;
  logic               start_acc, last_iter, early, finish;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .q_i    (q_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed && a[WIDTH-1];
  assign b_neg     = op_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  // In IDLE a simultaneous flush drops the start; in DONE flush is inert.
  assign start_acc = start && ((state_q == DONE) || ((state_q == IDLE) && !flush));
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MDU_EARLY_TERM_EN
  logic [CNT_W-1:0] rem_cnt;
  assign rem_cnt  = CNT_W'(WIDTH - 1) - cnt_q;
  assign early    = !is_div_q && ((step_q & ~({WIDTH{1'b1}} << rem_cnt)) == '0);
  assign prod_raw = {step_acc, step_q} >> rem_cnt;
`else
  assign early    = 1'b0;
  assign prod_raw = {step_acc, step_q};
`endif

  assign finish   = last_iter || early;
  assign prod_fix = neg_q ? -prod_raw : prod_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !flush) state_d = RUN;
      RUN:     if (flush) state_d = IDLE; else if (finish) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_op_d  = dz_op_q;
    dz_d     = dz_q;
    if (start_acc) begin
      cnt_d    = '0;
      acc_d    = '0;
      q_d      = op_div ? a_mag : b_mag;
      m_d      = op_div ? b_mag : a_mag;
      a_d      = a;
      is_div_d = op_div;
      neg_d    = a_neg ^ b_neg;
      rneg_d   = a_neg;
      dz_op_d  = op_div && (b == '0);
      dz_d     = 1'b0;
    end else if ((state_q == RUN) && !flush) begin
      acc_d = step_acc;
      q_d   = step_q;
      cnt_d = cnt_q + 1'b1;
      if (finish) begin
        dz_d = dz_op_q;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_op_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          // Remainder takes the dividend's sign; quotient truncates toward zero.
          hi_d = rneg_q ? -step_acc : step_acc;
          lo_d = neg_q ? -step_q : step_q;
        end
      end
    end
    if ((state_q != RUN) && wr_hi) hi_d = wdata;
    if ((state_q != RUN) && wr_lo) lo_d = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_op_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_op_q  <= dz_op_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/pipe_muldiv_unit.md
Name: pipe_muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that sits beside the EX stage of the pipelined core.
- Holds architectural HI/LO registers and executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Drives `busy` so the hazard unit can stall dependent instructions; `flush` from the hazard unit aborts an in-flight operation.
- Width is generic, so the same block serves the 32-bit core and narrower test configurations.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO (minimum 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation selected by `op` with operands `a`, `b`.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- flush  input  1  abort the current operation.
- wr_hi  input  1  direct write of HI (MTHI).
- wr_lo  input  1  direct write of LO (MTLO).
- wdata  input  WIDTH  data for wr_hi / wr_lo.
- busy  output  1  operation in progress; results not yet valid.
- done  output  1  single-cycle pulse: HI/LO hold a fresh result.
- div_by_zero  output  1  last accepted divide had b==0.
- hi  output  WIDTH  HI register (mult upper half / remainder).
- lo  output  WIDTH  LO register (mult lower half / quotient).

Behaviour:
- Reset (asynchronous, immediate): state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0; counter and work registers cleared. Reset mid-operation discards the operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start → RUN at the next edge. Operands are latched as magnitudes; result signs are latched for signed ops; counter=0.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per edge; counter increments.
  - RUN → DONE at the edge completing iteration WIDTH; HI/LO are loaded on that same edge.
  - DONE → IDLE next edge unless start is asserted.
- Timing: `busy` = (state==RUN). `done` = (state==DONE). With start sampled at edge 0, `done` is high in the cycle following edge WIDTH. Fixed latency is WIDTH+1 edges for every op, including divide-by-zero.
- `start` while RUN is ignored (the hazard unit must stall the pipeline).
- Arithmetic:
  - Multiply: 2*WIDTH product {hi,lo}; signed ops negate the product when operand signs differ.
  - Divide: truncates toward zero. `lo`=quotient; `hi`=remainder, with remainder sign equal to dividend sign.
  - MIN/−1 yields lo=MIN, hi=0 with no flag.
- Divide by zero: hi=a, lo=all ones, `div_by_zero`=1. The flag is set at the DONE load and cleared by the next accepted start.
- `flush` in RUN: return to IDLE at the next edge. No `done`; HI/LO keep their prior values. `flush` in IDLE or DONE has no effect.
- wr_hi/wr_lo: honoured only when not RUN and take effect at the next edge. In DONE, a direct write overrides the held result. A write together with start in IDLE is honoured, and the result later overwrites it. When `flush` and `start` arrive in the same cycle in IDLE, `flush` wins and start is dropped.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: MULT/MULTU leave RUN as soon as the remaining multiplier bits are all zero. The product is aligned by the remaining shift count and `done` fires early (minimum latency 2 edges for b==0). Divide latency is unchanged.
- Undefined: every op has fixed latency WIDTH+1.

Decomposition:
- Package `mdu_pkg`: op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, RUN, DONE).
- One sub-module, `mdu_step`: combinational single iteration (add-shift or compare-subtract-shift) on the {acc, q} work pair, selected by a mul/div flag.
- FSM, counter, sign fix-up and HI/LO registers live in the top.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
- MULT a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=100 b=0 → hi=0x64, lo=0xFFFFFFFF, div_by_zero=1; next MULTU start clears div_by_zero.
- Start MULTU, assert flush at iteration 10 with prior hi=0x11, lo=0x22 → busy=0 next cycle, no done pulse, hi/lo remain 0x11/0x22; a second start during RUN is ignored.
- wr_lo=1 wdata=0xABCD in IDLE → lo=0xABCD next edge; wr_hi during RUN → ignored; async rst mid-RUN → all outputs 0 immediately.
